// File: rtl/apu_note_sequencer.sv
// Frame-paced note sequencer feeding the APU pitch input, with manual-switch override.
// Optional per-step volume envelope enabled by defining APU_SEQ_ENVELOPE_EN.
module apu_note_sequencer #(
    parameter int LEN    = 16,
    parameter int LOOP   = 1,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_tick,
    input  logic              start,
    input  logic              stop,
    input  logic [3:0]        tempo,
    input  logic              manual_en,
    input  logic [7:0]        manual_pitch,
    output logic [7:0]        pitch,
    output logic              gate,
    output logic [STEP_W-1:0] step_idx,
    output logic              busy,
    output logic              loop_done,
    output logic [3:0]        vol
);

    localparam logic [0:0]        ST_IDLE   = 1'b0;
    localparam logic [0:0]        ST_PLAY   = 1'b1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(LEN - 1);

    function automatic logic [7:0] rom_lookup(input logic [3:0] idx);
        case (idx)
            4'd0:    rom_lookup = 8'h40;
            4'd1:    rom_lookup = 8'h40;
            4'd2:    rom_lookup = 8'h00;
            4'd3:    rom_lookup = 8'h50;
            4'd4:    rom_lookup = 8'h48;
            4'd5:    rom_lookup = 8'h40;
            4'd6:    rom_lookup = 8'h00;
            4'd7:    rom_lookup = 8'h36;
            4'd8:    rom_lookup = 8'h40;
            4'd9:    rom_lookup = 8'h40;
            4'd10:   rom_lookup = 8'h00;
            4'd11:   rom_lookup = 8'h50;
            4'd12:   rom_lookup = 8'h60;
            4'd13:   rom_lookup = 8'h50;
            4'd14:   rom_lookup = 8'h48;
            4'd15:   rom_lookup = 8'h00;
            default: rom_lookup = 8'h00;
        endcase
    endfunction

    logic [0:0]        r_state;
    logic [STEP_W-1:0] r_step_idx;
    logic [3:0]        r_frame_cnt;
    logic [3:0]        r_tempo_q;
    logic [7:0]        r_pitch;
    logic              r_gate;
    logic              r_busy;
    logic              r_loop_done;
    logic [3:0]        r_vol;

    logic [0:0]        w_state_nxt;
    logic [STEP_W-1:0] w_step_nxt;
    logic [3:0]        w_cnt_nxt;
    logic [3:0]        w_tq_nxt;
    logic              w_loop_done_nxt;
    logic [7:0]        w_pitch_nxt;
    logic              w_gate_nxt;
    logic [3:0]        w_vol_nxt;

    // Playback FSM: stop beats start, start beats frame_tick.
    always_comb begin
        w_state_nxt     = r_state;
        w_step_nxt      = r_step_idx;
        w_cnt_nxt       = r_frame_cnt;
        w_tq_nxt        = r_tempo_q;
        w_loop_done_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && !stop) begin
                    w_state_nxt = ST_PLAY;
                    w_step_nxt  = '0;
                    w_cnt_nxt   = 4'd0;
                    w_tq_nxt    = tempo;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_PLAY: begin
                if (stop) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 4'd0;
                end else if (start) begin
                    w_step_nxt = '0;
                    w_cnt_nxt  = 4'd0;
                    w_tq_nxt   = tempo;
                end else if (frame_tick) begin
                    if (r_frame_cnt == r_tempo_q) begin
                        w_cnt_nxt = 4'd0;
                        w_tq_nxt  = tempo;
                        if (r_step_idx == LAST_STEP) begin
                            w_loop_done_nxt = 1'b1;
                            w_step_nxt      = '0;
                            if (LOOP == 0) begin
                                w_state_nxt = ST_IDLE;
                            end else begin
                                w_state_nxt = ST_PLAY;
                            end
                        end else begin
                            w_step_nxt = r_step_idx + STEP_W'(1);
                        end
                    end else begin
                        w_cnt_nxt = r_frame_cnt + 4'd1;
                    end
                end else begin
                    w_cnt_nxt = r_frame_cnt;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_step_nxt  = '0;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    // Pitch source follows the current (pre-edge) state, giving one cycle of lag.
    always_comb begin
        w_pitch_nxt = 8'h00;
        if (manual_en) begin
            w_pitch_nxt = manual_pitch;
        end else if (r_state == ST_PLAY) begin
            w_pitch_nxt = rom_lookup(4'(r_step_idx));
        end else begin
            w_pitch_nxt = 8'h00;
        end
    end

`ifdef APU_SEQ_ENVELOPE_EN
    logic w_vol_load;
    logic w_vol_dec;

    // Envelope: reload on start/step advance, decay per frame, manual pins it at full.
    always_comb begin
        w_vol_load = 1'b0;
        w_vol_dec  = 1'b0;
        w_vol_nxt  = r_vol;
        if (r_state == ST_IDLE) begin
            w_vol_load = start && !stop;
        end else begin
            w_vol_load = !stop && (start || (frame_tick && (r_frame_cnt == r_tempo_q)));
            w_vol_dec  = !stop && !start && frame_tick;
        end
        if (manual_en || w_vol_load) begin
            w_vol_nxt = 4'hF;
        end else if (w_vol_dec && (r_vol != 4'h0)) begin
            w_vol_nxt = r_vol - 4'h1;
        end else begin
            w_vol_nxt = r_vol;
        end
        w_gate_nxt = (w_pitch_nxt != 8'h00) && (manual_en || (r_vol != 4'h0));
    end
`else
    // Without the envelope the level is fixed and gate tracks pitch alone.
    always_comb begin
        w_vol_nxt  = 4'hF;
        w_gate_nxt = (w_pitch_nxt != 8'h00);
    end
`endif

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_step_idx  <= '0;
            r_frame_cnt <= 4'd0;
            r_tempo_q   <= 4'd0;
            r_pitch     <= 8'h00;
            r_gate      <= 1'b0;
            r_busy      <= 1'b0;
            r_loop_done <= 1'b0;
            r_vol       <= 4'hF;
        end else begin
            r_state     <= w_state_nxt;
            r_step_idx  <= w_step_nxt;
            r_frame_cnt <= w_cnt_nxt;
            r_tempo_q   <= w_tq_nxt;
            r_pitch     <= w_pitch_nxt;
            r_gate      <= w_gate_nxt;
            r_busy      <= (w_state_nxt == ST_PLAY);
            r_loop_done <= w_loop_done_nxt;
            r_vol       <= w_vol_nxt;
        end
    end

    assign pitch     = r_pitch;
    assign gate      = r_gate;
    assign step_idx  = r_step_idx;
    assign busy      = r_busy;
    assign loop_done = r_loop_done;
    assign vol       = r_vol;

endmodule

// File: tb/tb_apu_note_sequencer.sv
// Scoreboard bench for apu_note_sequencer: a looping 16-step instance and a 5-step one-shot instance
// share stimulus; a reference model pushes expected outputs that a monitor pops after each edge.
module tb_apu_note_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_tick, start, stop, manual_en;
    logic [3:0] tempo;
    logic [7:0] manual_pitch;

    logic [7:0] p0, p1;
    logic       g0, g1, b0, b1, ld0, ld1;
    logic [3:0] s0, v0, v1;
    logic [2:0] s1;

    int tests  = 0;
    int failed = 0;

    apu_note_sequencer #(.LEN(16), .LOOP(1), .STEP_W(4)) dut0 (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start), .stop(stop),
        .tempo(tempo), .manual_en(manual_en), .manual_pitch(manual_pitch),
        .pitch(p0), .gate(g0), .step_idx(s0), .busy(b0), .loop_done(ld0), .vol(v0));

    apu_note_sequencer #(.LEN(5), .LOOP(0), .STEP_W(3)) dut1 (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start), .stop(stop),
        .tempo(tempo), .manual_en(manual_en), .manual_pitch(manual_pitch),
        .pitch(p1), .gate(g1), .step_idx(s1), .busy(b1), .loop_done(ld1), .vol(v1));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [0:0] id;
        logic [7:0] p;
        logic       g;
        logic [3:0] s;
        logic       b;
        logic       ld;
        logic [3:0] v;
    } exp_t;

    exp_t q[$];

    logic [7:0] rom [16] = '{8'h40, 8'h40, 8'h00, 8'h50, 8'h48, 8'h40, 8'h00, 8'h36,
                             8'h40, 8'h40, 8'h00, 8'h50, 8'h60, 8'h50, 8'h48, 8'h00};
    int m_len  [2] = '{16, 5};
    int m_loop [2] = '{1, 0};
    bit m_play [2];
    int m_step [2];
    int m_cnt  [2];
    int m_tq   [2];
    int m_vol  [2];

    task automatic check(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_play[i] = 1'b0; m_step[i] = 0; m_cnt[i] = 0; m_tq[i] = 0; m_vol[i] = 15;
        end
    endtask

    // Advance the reference by one clock using the inputs currently driven.
    task automatic model_step();
        exp_t e;
        int   np;
        bit   adv, restart;
        for (int i = 0; i < 2; i++) begin
            np = manual_en ? int'(manual_pitch) : (m_play[i] ? int'(rom[m_step[i]]) : 0);
            e.g = (np != 0);
`ifdef APU_SEQ_ENVELOPE_EN
            e.g = (np != 0) && (manual_en || m_vol[i] != 0);
`endif
            e.ld = 1'b0; adv = 1'b0; restart = 1'b0;
            if (m_play[i]) begin
                if (stop) begin
                    m_play[i] = 1'b0; m_cnt[i] = 0;
                end else if (start) begin
                    restart = 1'b1;
                end else if (frame_tick) begin
                    if (m_cnt[i] == m_tq[i]) begin
                        adv = 1'b1; m_cnt[i] = 0; m_tq[i] = int'(tempo);
                        if (m_step[i] == m_len[i] - 1) begin
                            e.ld = 1'b1; m_step[i] = 0;
                            if (m_loop[i] == 0) m_play[i] = 1'b0;
                        end else begin
                            m_step[i]++;
                        end
                    end else begin
                        m_cnt[i]++;
                        if (m_vol[i] > 0) m_vol[i]--;
                    end
                end
            end else if (start && !stop) begin
                m_play[i] = 1'b1; restart = 1'b1;
            end
            if (restart) begin
                m_step[i] = 0; m_cnt[i] = 0; m_tq[i] = int'(tempo);
            end
            if (restart || adv || manual_en) m_vol[i] = 15;
`ifndef APU_SEQ_ENVELOPE_EN
            m_vol[i] = 15;
`endif
            e.id = 1'(i); e.p = 8'(np); e.s = 4'(m_step[i]); e.b = m_play[i]; e.v = 4'(m_vol[i]);
            q.push_back(e);
        end
    endtask

    task automatic drive(input bit ft, input bit st, input bit sp, input logic [3:0] tp,
                         input bit me, input logic [7:0] mp);
        frame_tick = ft; start = st; stop = sp; tempo = tp; manual_en = me; manual_pitch = mp;
        model_step();
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " pitch0"}, p0, 8'h00);  check({tag, " gate0"}, g0, 0);
        check({tag, " step0"}, s0, 0);       check({tag, " busy0"}, b0, 0);
        check({tag, " ld0"}, ld0, 0);        check({tag, " vol0"}, v0, 4'hF);
        check({tag, " pitch1"}, p1, 8'h00);  check({tag, " busy1"}, b1, 0);
        check({tag, " step1"}, s1, 0);       check({tag, " vol1"}, v1, 4'hF);
    endtask

    // Asynchronous reset in the middle of a low clock phase, checked before the next edge.
    task automatic mid_reset();
        reset = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        model_reset();
        #1;
        reset = 1'b0;
    endtask

    // Monitor: compare every expected entry once the edge it predicts has settled.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            while (q.size() > 0) begin
                e = q.pop_front();
                if (e.id == 1'b0) begin
                    check("d0.pitch", p0, e.p);   check("d0.gate", g0, e.g);
                    check("d0.step", s0, e.s);    check("d0.busy", b0, e.b);
                    check("d0.loop_done", ld0, e.ld); check("d0.vol", v0, e.v);
                end else begin
                    check("d1.pitch", p1, e.p);   check("d1.gate", g1, e.g);
                    check("d1.step", {1'b0, s1}, e.s); check("d1.busy", b1, e.b);
                    check("d1.loop_done", ld1, e.ld); check("d1.vol", v1, e.v);
                end
            end
        end
    end

    initial begin
        int         man_hold;
        bit         me;
        logic [7:0] mp;
        reset = 1'b1; frame_tick = 1'b0; start = 1'b0; stop = 1'b0;
        tempo = 4'd0; manual_en = 1'b0; manual_pitch = 8'h00;
        model_reset();
        @(negedge clk); @(negedge clk);
        check_reset_outputs("por");
        reset = 1'b0;

        // tempo=1: two ticks per step, rest reached at the fourth tick
        drive(0, 1, 0, 4'd1, 0, 8'h00);
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 0, 4'd1, 0, 8'h00);
            drive(1, 0, 0, 4'd1, 0, 8'h00);
        end
        drive(0, 0, 0, 4'd0, 0, 8'h00);

        // tempo=0 full pass: loop_done on both instances, one-shot returns to idle
        drive(0, 1, 0, 4'd0, 0, 8'h00);
        for (int k = 0; k < 20; k++) drive(1, 0, 0, 4'd0, 0, 8'h00);
        drive(0, 0, 0, 4'd0, 0, 8'h00);

        // manual override at step 3, sequencer keeps counting underneath
        drive(0, 1, 0, 4'd0, 0, 8'h00);
        for (int k = 0; k < 3; k++) drive(1, 0, 0, 4'd0, 0, 8'h00);
        drive(0, 0, 0, 4'd0, 1, 8'h7A);
        drive(1, 0, 0, 4'd0, 1, 8'h7A);
        drive(1, 0, 0, 4'd0, 1, 8'h7A);
        drive(0, 0, 0, 4'd0, 0, 8'h00);
        drive(0, 0, 0, 4'd0, 0, 8'h00);

        // start+stop together, then start with a coincident tick
        drive(0, 1, 1, 4'd0, 0, 8'h00);
        drive(0, 0, 0, 4'd0, 0, 8'h00);
        drive(1, 1, 0, 4'd2, 0, 8'h00);
        for (int k = 0; k < 4; k++) drive(1, 0, 0, 4'd2, 0, 8'h00);
        drive(0, 0, 1, 4'd2, 0, 8'h00);
        drive(0, 0, 0, 4'd2, 0, 8'h00);

        // slowest tempo exercises full envelope decay and reload
        drive(0, 1, 0, 4'd15, 0, 8'h00);
        for (int k = 0; k < 18; k++) begin
            drive(1, 0, 0, 4'd15, 0, 8'h00);
            drive(0, 0, 0, 4'd15, 0, 8'h00);
        end

        // randomized traffic with occasional asynchronous resets
        man_hold = 0; me = 1'b0; mp = 8'h00;
        for (int c = 0; c < 4000; c++) begin
            if (man_hold == 0) begin
                me = ($urandom % 4) == 0;
                mp = (($urandom % 5) == 0) ? 8'h00 : 8'($urandom);
                man_hold = $urandom_range(1, 20);
            end
            man_hold--;
            drive(($urandom % 3) != 0, ($urandom % 50) == 0, ($urandom % 80) == 0,
                  (($urandom % 8) == 0) ? 4'($urandom) : 4'($urandom % 3), me, mp);
            if ((c % 997) == 500) mid_reset();
        end

        drive(0, 0, 0, 4'd0, 0, 8'h00);
        @(negedge clk);
        check("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
